// File: rtl/reg_display_pkg.sv
// ============================================================================
// Module   : reg_display_pkg
// Purpose  : Shared widths and active-low seven-segment codes {g,f,e,d,c,b,a}
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_display_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;
  localparam int SEG_W  = 7;
  localparam int BCD_W  = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'd64;
  localparam logic [SEG_W-1:0] SEG_1     = 7'd121;
  localparam logic [SEG_W-1:0] SEG_2     = 7'd36;
  localparam logic [SEG_W-1:0] SEG_3     = 7'd48;
  localparam logic [SEG_W-1:0] SEG_4     = 7'd25;
  localparam logic [SEG_W-1:0] SEG_5     = 7'd18;
  localparam logic [SEG_W-1:0] SEG_6     = 7'd2;
  localparam logic [SEG_W-1:0] SEG_7     = 7'd120;
  localparam logic [SEG_W-1:0] SEG_8     = 7'd0;
  localparam logic [SEG_W-1:0] SEG_9     = 7'd16;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'd127;

  // Any digit code above 9 decodes to a blank display
  localparam logic [BCD_W-1:0] DIGIT_BLANK = 4'd15;

endpackage

`default_nettype wire

// File: rtl/reg_display_decoder_seg7.sv
// ============================================================================
// Module   : seg7_digit_decoder
// Purpose  : Combinational BCD digit to active-low seven-segment decoder
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_digit_decoder
  import reg_display_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  output logic [SEG_W-1:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/reg_display_decoder.sv
// ============================================================================
// Module   : reg_display_decoder
// Purpose  : Selects one of eight CPU registers, converts it to BCD and drives
//            four registered active-low seven-segment displays.
//            Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_display_decoder
  import reg_display_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] R0,
  input  logic [DATA_W-1:0] R1,
  input  logic [DATA_W-1:0] R2,
  input  logic [DATA_W-1:0] R3,
  input  logic [DATA_W-1:0] R4,
  input  logic [DATA_W-1:0] R5,
  input  logic [DATA_W-1:0] R6,
  input  logic [DATA_W-1:0] R7,
  input  logic [SEL_W-1:0]  SEL,
  output logic [DATA_W-1:0] BIN,
  output logic [BCD_W-1:0]  BCD2,
  output logic [BCD_W-1:0]  BCD1,
  output logic [BCD_W-1:0]  BCD0,
  output logic [SEG_W-1:0]  HEX3,
  output logic [SEG_W-1:0]  HEX2,
  output logic [SEG_W-1:0]  HEX1,
  output logic [SEG_W-1:0]  HEX0
);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [SEG_W-1:0] c_hex_lead_rst = SEG_BLANK;
`else
  localparam logic [SEG_W-1:0] c_hex_lead_rst = SEG_0;
`endif

  logic [DATA_W-1:0] w_sel_val;
  logic [11:0]       w_bcd;
  logic [BCD_W-1:0]  w_dig3, w_dig2, w_dig1, w_dig0;
  logic [SEG_W-1:0]  w_seg3, w_seg2, w_seg1, w_seg0;

  logic [DATA_W-1:0] r_bin;
  logic [BCD_W-1:0]  r_bcd2, r_bcd1, r_bcd0;
  logic [SEG_W-1:0]  r_hex3, r_hex2, r_hex1, r_hex0;

  always_comb begin
    w_sel_val = R0;
    case (SEL)
      3'd0: w_sel_val = R0;
      3'd1: w_sel_val = R1;
      3'd2: w_sel_val = R2;
      3'd3: w_sel_val = R3;
      3'd4: w_sel_val = R4;
      3'd5: w_sel_val = R5;
      3'd6: w_sel_val = R6;
      3'd7: w_sel_val = R7;
    endcase
  end

  // Shift-add-3: adjust each digit >= 5 before shifting in the next bit
  always_comb begin
    logic [DATA_W-1:0] v_bin;
    w_bcd = '0;
    v_bin = w_sel_val;
    for (int i = 0; i < DATA_W; i++) begin
      if (w_bcd[3:0]  >= 4'd5) w_bcd[3:0]  = w_bcd[3:0]  + 4'd3;
      if (w_bcd[7:4]  >= 4'd5) w_bcd[7:4]  = w_bcd[7:4]  + 4'd3;
      if (w_bcd[11:8] >= 4'd5) w_bcd[11:8] = w_bcd[11:8] + 4'd3;
      w_bcd = {w_bcd[10:0], v_bin[DATA_W-1]};
      v_bin = {v_bin[DATA_W-2:0], 1'b0};
    end
  end

  // Blanked digits are steered to a code the decoder renders as blank
  always_comb begin
    w_dig0 = w_bcd[3:0];
`ifdef LEADING_ZERO_BLANK_EN
    w_dig3 = DIGIT_BLANK;
    w_dig2 = (w_bcd[11:8] == 4'd0) ? DIGIT_BLANK : w_bcd[11:8];
    w_dig1 = (w_bcd[11:4] == 8'd0) ? DIGIT_BLANK : w_bcd[7:4];
`else
    w_dig3 = 4'd0;
    w_dig2 = w_bcd[11:8];
    w_dig1 = w_bcd[7:4];
`endif
  end

  seg7_digit_decoder u_dec3 (.i_bcd(w_dig3), .o_seg(w_seg3));
  seg7_digit_decoder u_dec2 (.i_bcd(w_dig2), .o_seg(w_seg2));
  seg7_digit_decoder u_dec1 (.i_bcd(w_dig1), .o_seg(w_seg1));
  seg7_digit_decoder u_dec0 (.i_bcd(w_dig0), .o_seg(w_seg0));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_bin  <= '0;
      r_bcd2 <= '0;
      r_bcd1 <= '0;
      r_bcd0 <= '0;
      r_hex3 <= c_hex_lead_rst;
      r_hex2 <= c_hex_lead_rst;
      r_hex1 <= c_hex_lead_rst;
      r_hex0 <= SEG_0;
    end else begin
      r_bin  <= w_sel_val;
      r_bcd2 <= w_bcd[11:8];
      r_bcd1 <= w_bcd[7:4];
      r_bcd0 <= w_bcd[3:0];
      r_hex3 <= w_seg3;
      r_hex2 <= w_seg2;
      r_hex1 <= w_seg1;
      r_hex0 <= w_seg0;
    end
  end

  assign BIN  = r_bin;
  assign BCD2 = r_bcd2;
  assign BCD1 = r_bcd1;
  assign BCD0 = r_bcd0;
  assign HEX3 = r_hex3;
  assign HEX2 = r_hex2;
  assign HEX1 = r_hex1;
  assign HEX0 = r_hex0;

endmodule

`default_nettype wire

// File: tb/tb_reg_display_decoder.sv
// ============================================================================
// Module   : tb_reg_display_decoder
// Purpose  : Randomized self-checking bench for reg_display_decoder against an
//            arithmetic reference model. Honours LEADING_ZERO_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_display_decoder;

  localparam logic [6:0] SEG_TBL [10] = '{7'd64, 7'd121, 7'd36, 7'd48, 7'd25,
                                          7'd18, 7'd2,   7'd120, 7'd0, 7'd16};
  localparam logic [6:0] BLANK = 7'd127;

  logic       CLK;
  logic       RESET;
  logic [7:0] r [8];
  logic [2:0] SEL;
  logic [7:0] BIN;
  logic [3:0] BCD2, BCD1, BCD0;
  logic [6:0] HEX3, HEX2, HEX1, HEX0;

  int n_tests;
  int n_fail;

  reg_display_decoder dut (
    .CLK(CLK), .RESET(RESET),
    .R0(r[0]), .R1(r[1]), .R2(r[2]), .R3(r[3]),
    .R4(r[4]), .R5(r[5]), .R6(r[6]), .R7(r[7]),
    .SEL(SEL), .BIN(BIN),
    .BCD2(BCD2), .BCD1(BCD1), .BCD0(BCD0),
    .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: displayed digits computed by decimal arithmetic on v
  task automatic check_value(input string tag, input int v);
    int h, t, u;
    logic [6:0] e3, e2, e1, e0;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
`ifdef LEADING_ZERO_BLANK_EN
    e3 = BLANK;
    e2 = (h == 0) ? BLANK : SEG_TBL[h];
    e1 = (h == 0 && t == 0) ? BLANK : SEG_TBL[t];
`else
    e3 = SEG_TBL[0];
    e2 = SEG_TBL[h];
    e1 = SEG_TBL[t];
`endif
    e0 = SEG_TBL[u];
    check({tag, ".bin"},  32'(BIN),  32'(v));
    check({tag, ".bcd2"}, 32'(BCD2), 32'(h));
    check({tag, ".bcd1"}, 32'(BCD1), 32'(t));
    check({tag, ".bcd0"}, 32'(BCD0), 32'(u));
    check({tag, ".hex3"}, 32'(HEX3), 32'(e3));
    check({tag, ".hex2"}, 32'(HEX2), 32'(e2));
    check({tag, ".hex1"}, 32'(HEX1), 32'(e1));
    check({tag, ".hex0"}, 32'(HEX0), 32'(e0));
  endtask

  task automatic check_reset(input string tag);
    logic [6:0] lead;
`ifdef LEADING_ZERO_BLANK_EN
    lead = BLANK;
`else
    lead = SEG_TBL[0];
`endif
    check({tag, ".bin"},  32'(BIN),  0);
    check({tag, ".bcd2"}, 32'(BCD2), 0);
    check({tag, ".bcd1"}, 32'(BCD1), 0);
    check({tag, ".bcd0"}, 32'(BCD0), 0);
    check({tag, ".hex3"}, 32'(HEX3), 32'(lead));
    check({tag, ".hex2"}, 32'(HEX2), 32'(lead));
    check({tag, ".hex1"}, 32'(HEX1), 32'(lead));
    check({tag, ".hex0"}, 32'(HEX0), 32'(SEG_TBL[0]));
  endtask

  task automatic randomize_regs();
    for (int i = 0; i < 8; i++) r[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int v;
    int sel_i;
    n_tests = 0;
    n_fail  = 0;

    // Reset asserted before the first clock edge
    RESET = 1'b1;
    randomize_regs();
    SEL = 3'($urandom_range(0, 7));
    #2;
    check_reset("rst_noclk");

    @(negedge CLK);
    RESET = 1'b0;
    SEL = 3'd0;
    r[0] = 8'd0;
    tick();
    check_value("v0", 0);

    r[0] = 8'd255;
    tick();
    check_value("v255", 255);

    SEL = 3'd5;
    r[5] = 8'd123;
    tick();
    check_value("v123", 123);

    // Input change between edges must not reach the outputs early
    #2;
    SEL = 3'd7;
    r[7] = 8'd9;
    #1;
    check_value("hold123", 123);
    tick();
    check_value("v9", 9);

    SEL = 3'd2;
    r[2] = 8'd99;
    tick();
    check_value("v99", 99);
    r[2] = 8'd100;
    tick();
    check_value("v100", 100);

    // Exhaustive value sweep on every select, other registers random
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < 256; k++) begin
        randomize_regs();
        SEL = 3'(s);
        r[s] = 8'(k);
        tick();
        check_value("sweep", k);
      end
    end

    // Fully random select and data
    for (int n = 0; n < 300; n++) begin
      randomize_regs();
      sel_i = $urandom_range(0, 7);
      SEL = 3'(sel_i);
      v = int'(r[sel_i]);
      tick();
      check_value("rand", v);
    end

    // Asynchronous reset mid-stream
    SEL = 3'd0;
    r[0] = 8'd200;
    tick();
    check_value("v200", 200);
    #2;
    RESET = 1'b1;
    #1;
    check_reset("rst_async");
    #1;
    RESET = 1'b0;
    #1;
    check_reset("rst_released");
    tick();
    check_value("v200_after", 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
